vga_sync_gen: RTL and testbench

- Timing generator that produces the pixel coordinate and blanking interface consumed by the screen-object renderers (barrier, sprites, etc.), plus the monitor sync pulses.
- Default timing: SVGA 800x600@60 Hz (40 MHz pixel rate) with free-running horizontal and vertical counters.
- Sits between the clock/reset logic and every pixel renderer and the colour mux.

---
 rtl/vga_sync_gen.sv | 145 ++++++++++++++
 tb/tb_vga_sync_gen.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: free-running raster timing generator (pixel coordinate,
// active-video flag, monitor sync pulses, line/frame start strobes).
// Default timing is SVGA 800x600@60 Hz at a 40 MHz pixel rate.
// Optional build macro VGA_SYNC_PIPE_EN: delays active/h_sync/v_sync by one
// enabled cycle so they line up with a one-cycle ROM read in the renderers.
// Timing parameters must satisfy H_TOTAL <= 2048 and V_TOTAL <= 1024.

module vga_sync_gen #(
    parameter int unsigned H_VISIBLE = 800,
    parameter int unsigned H_FP      = 40,
    parameter int unsigned H_SYNC    = 128,
    parameter int unsigned H_BP      = 88,
    parameter int unsigned V_VISIBLE = 600,
    parameter int unsigned V_FP      = 1,
    parameter int unsigned V_SYNC    = 4,
    parameter int unsigned V_BP      = 23,
    parameter int unsigned SYNC_POL  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [10:0] p_x,
    output logic [9:0]  p_y,
    output logic        active,
    output logic        h_sync,
    output logic        v_sync,
    output logic        line_start,
    output logic        frame_start
);

    localparam int unsigned X_W      = 11;
    localparam int unsigned Y_W      = 10;
    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_VISIBLE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_VISIBLE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    // Last coordinate of the raster; also the reset position so that the
    // first enabled cycle lands on (0,0).
    localparam logic [X_W-1:0] X_LAST = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_TOTAL - 1);

    localparam logic SYNC_ON  = 1'(SYNC_POL);
    localparam logic SYNC_OFF = ~SYNC_ON;

    logic [X_W-1:0] x_nxt;
    logic [Y_W-1:0] y_nxt;
    logic           x_wrap;
    logic           act_nxt;
    logic           hs_nxt;
    logic           vs_nxt;

    // Next raster position: x advances every pixel, y on each x wrap.
    always_comb begin
        x_nxt  = p_x + X_W'(1);
        y_nxt  = p_y;
        x_wrap = (p_x == X_LAST);
        if (x_wrap) begin
            x_nxt = '0;
            if (p_y == Y_LAST) begin
                y_nxt = '0;
            end else begin
                y_nxt = p_y + Y_W'(1);
            end
        end
    end

    // Flag decode from the next position; one extra bit keeps compares safe
    // when a window ends exactly at 2048 / 1024.
    always_comb begin
        act_nxt = ({1'b0, x_nxt} < 12'(H_VISIBLE)) &&
                  ({1'b0, y_nxt} < 11'(V_VISIBLE));
        hs_nxt  = (({1'b0, x_nxt} >= 12'(HS_START)) &&
                   ({1'b0, x_nxt} <  12'(HS_END))) ? SYNC_ON : SYNC_OFF;
        vs_nxt  = (({1'b0, y_nxt} >= 11'(VS_START)) &&
                   ({1'b0, y_nxt} <  11'(VS_END))) ? SYNC_ON : SYNC_OFF;
    end

    // Coordinate counters and start strobes; strobes last one clock only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_x         <= X_LAST;
            p_y         <= Y_LAST;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            if (en) begin
                p_x         <= x_nxt;
                p_y         <= y_nxt;
                line_start  <= (x_nxt == '0);
                frame_start <= (x_nxt == '0) && (y_nxt == '0);
            end
        end
    end

`ifdef VGA_SYNC_PIPE_EN
    logic act_s1;
    logic hs_s1;
    logic vs_s1;

    // First flag stage: aligned with p_x/p_y.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            act_s1 <= 1'b0;
            hs_s1  <= SYNC_OFF;
            vs_s1  <= SYNC_OFF;
        end else if (en) begin
            act_s1 <= act_nxt;
            hs_s1  <= hs_nxt;
            vs_s1  <= vs_nxt;
        end
    end

    // Second flag stage: one enabled cycle behind the coordinate.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active <= 1'b0;
            h_sync <= SYNC_OFF;
            v_sync <= SYNC_OFF;
        end else if (en) begin
            active <= act_s1;
            h_sync <= hs_s1;
            v_sync <= vs_s1;
        end
    end
`else
    // Flags registered from the next position: same pixel as p_x/p_y.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active <= 1'b0;
            h_sync <= SYNC_OFF;
            v_sync <= SYNC_OFF;
        end else if (en) begin
            active <= act_nxt;
            h_sync <= hs_nxt;
            v_sync <= vs_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default SVGA instance for one line, plus a tiny
// negative-sync instance (16x8 raster) for full frames, en gating and reset.
`timescale 1ns/1ps

module tb_vga_sync_gen;

`ifdef VGA_SYNC_PIPE_EN
    localparam bit PIPE = 1'b1;
`else
    localparam bit PIPE = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic en_d;
    logic en_s;

    always #5 clk = ~clk;

    logic [10:0] d_px, s_px;
    logic [9:0]  d_py, s_py;
    logic d_act, d_hs, d_vs, d_ls, d_fs;
    logic s_act, s_hs, s_vs, s_ls, s_fs;

    vga_sync_gen dut_d (
        .clk(clk), .reset(reset), .en(en_d),
        .p_x(d_px), .p_y(d_py), .active(d_act), .h_sync(d_hs), .v_sync(d_vs),
        .line_start(d_ls), .frame_start(d_fs)
    );

    // 16 pixels/line (visible 0..7, sync 10..12), 8 lines (visible 0..3,
    // sync 5..6), active-low sync.
    vga_sync_gen #(
        .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(0)
    ) dut_s (
        .clk(clk), .reset(reset), .en(en_s),
        .p_x(s_px), .p_y(s_py), .active(s_act), .h_sync(s_hs), .v_sync(s_vs),
        .line_start(s_ls), .frame_start(s_fs)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected {active, h_sync, v_sync} for the small raster.
    function automatic logic [2:0] sdec(input int x, input int y);
        logic a, h, v;
        a = (x < 8) && (y < 4);
        h = (x >= 10 && x < 13) ? 1'b0 : 1'b1;
        v = (y >= 5 && y < 7) ? 1'b0 : 1'b1;
        return {a, h, v};
    endfunction

    int mx = 15;
    int my = 7;
    logic [2:0] fexp = 3'b011;

    // One clock on the small instance with model update and full compare.
    task automatic sstep(input logic e);
        int ox, oy;
        logic ls, fs;
        en_s = e;
        step();
        ox = mx;
        oy = my;
        if (e) begin
            if (mx == 15) begin
                mx = 0;
                my = (my == 7) ? 0 : my + 1;
            end else begin
                mx = mx + 1;
            end
            fexp = PIPE ? sdec(ox, oy) : sdec(mx, my);
        end
        ls = e && (mx == 0);
        fs = ls && (my == 0);
        check("s_px", 32'(s_px), 32'(mx));
        check("s_py", 32'(s_py), 32'(my));
        check("s_active", 32'(s_act), 32'(fexp[2]));
        check("s_hsync", 32'(s_hs), 32'(fexp[1]));
        check("s_vsync", 32'(s_vs), 32'(fexp[0]));
        check("s_line_start", 32'(s_ls), 32'(ls));
        check("s_frame_start", 32'(s_fs), 32'(fs));
    endtask

    initial begin
        int hs_cnt, hs_first, hs_last, act_fall, x;
        logic prev_act;
        int vs_cnt, fs1, fs2;
        bit found;

        reset = 1'b0;
        en_d  = 1'b0;
        en_s  = 1'b0;
        #12;

        // Reset state of both instances.
        check("rst_d_px", 32'(d_px), 1055);
        check("rst_d_py", 32'(d_py), 627);
        check("rst_d_active", 32'(d_act), 0);
        check("rst_d_hsync", 32'(d_hs), 0);
        check("rst_d_vsync", 32'(d_vs), 0);
        check("rst_d_ls", 32'(d_ls), 0);
        check("rst_d_fs", 32'(d_fs), 0);
        check("rst_s_px", 32'(s_px), 15);
        check("rst_s_py", 32'(s_py), 7);
        check("rst_s_hsync", 32'(s_hs), 1);
        check("rst_s_vsync", 32'(s_vs), 1);

        step();
        reset = 1'b1;
        en_d  = 1'b1;

        // First enabled cycle lands on (0,0) with both strobes.
        step();
        check("first_px", 32'(d_px), 0);
        check("first_py", 32'(d_py), 0);
        check("first_active", 32'(d_act), PIPE ? 0 : 1);
        check("first_ls", 32'(d_ls), 1);
        check("first_fs", 32'(d_fs), 1);
        step();
        check("second_px", 32'(d_px), 1);
        check("second_ls", 32'(d_ls), 0);
        check("second_fs", 32'(d_fs), 0);

        // Rest of the first line, measuring sync and active windows.
        hs_cnt   = 0;
        hs_first = -1;
        hs_last  = -1;
        act_fall = -1;
        prev_act = d_act;
        for (int k = 2; k <= 1056; k++) begin
            step();
            x = int'(d_px);
            if (d_hs) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = x;
                hs_last = x;
            end
            if (prev_act && !d_act && act_fall < 0) act_fall = x;
            prev_act = d_act;
        end
        check("line_wrap_px", 32'(d_px), 0);
        check("line_wrap_py", 32'(d_py), 1);
        check("line_wrap_ls", 32'(d_ls), 1);
        check("line_wrap_fs", 32'(d_fs), 0);
        check("hsync_width", 32'(hs_cnt), 128);
        check("hsync_first", 32'(hs_first), PIPE ? 841 : 840);
        check("hsync_last", 32'(hs_last), PIPE ? 968 : 967);
        check("active_fall_x", 32'(act_fall), PIPE ? 801 : 800);

        // Small instance was idle throughout: it must still sit at reset.
        check("hold_s_px", 32'(s_px), 15);
        check("hold_s_py", 32'(s_py), 7);

        // Disabling the default instance holds coordinates, drops strobes.
        en_d = 1'b0;
        step();
        step();
        check("hold_d_px", 32'(d_px), 0);
        check("hold_d_py", 32'(d_py), 1);
        check("hold_d_ls", 32'(d_ls), 0);

        // Full frames on the small instance with en constantly high.
        vs_cnt = 0;
        fs1 = -1;
        fs2 = -1;
        for (int k = 1; k <= 130; k++) begin
            sstep(1'b1);
            if (k <= 128 && s_vs == 1'b0) vs_cnt++;
            if (s_fs) begin
                if (fs1 < 0) fs1 = k;
                else if (fs2 < 0) fs2 = k;
            end
            if (k == 128) begin
                check("frame_end_px", 32'(s_px), 15);
                check("frame_end_py", 32'(s_py), 7);
            end
        end
        check("vsync_cycles", 32'(vs_cnt), 32);
        check("frame_period", 32'(fs2 - fs1), 128);

        // Alternating en: counters advance every other clock.
        fs1 = -1;
        fs2 = -1;
        for (int i = 0; i < 600; i++) begin
            sstep((i % 2) == 0);
            if (s_fs) begin
                if (fs1 < 0) fs1 = i;
                else if (fs2 < 0) fs2 = i;
            end
        end
        check("half_rate_frame_clk", 32'(fs2 - fs1), 256);

        // Reset in the middle of a frame acts without a clock edge.
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            sstep(1'b1);
            if (mx == 5 && my == 3) found = 1'b1;
        end
        check("reach_mid_frame", 32'(found), 1);
        reset = 1'b0;
        #1;
        check("async_s_px", 32'(s_px), 15);
        check("async_s_py", 32'(s_py), 7);
        check("async_s_active", 32'(s_act), 0);
        check("async_s_hsync", 32'(s_hs), 1);
        check("async_s_vsync", 32'(s_vs), 1);
        check("async_d_px", 32'(d_px), 1055);
        check("async_d_py", 32'(d_py), 627);
        check("async_d_active", 32'(d_act), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
